axi_r_line_assembler: RTL
=========================

AXI_R_LINE_ASSEMBLER -- requirements
Module: axi_r_line_assembler

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, the AXI ID width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, the R beat data width.
REQ-003 SHALL have parameter USER_WIDTH, default 6, the R user width.
REQ-004 SHALL have parameter LINE_BEATS, default 4, the beats per line (power of two, 2..16).
REQ-005 SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-006 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_i, input, 1, the synchronous active-high reset.
REQ-008 SHALL have ports slave_valid_i / slave_ready_o, input / output, 1 each, the R-beat handshake from the upstream R buffer.
REQ-009 SHALL have ports slave_data_i [DATA_WIDTH], slave_resp_i [2], slave_user_i [USER_WIDTH], slave_id_i [ID_WIDTH] and slave_last_i [1], all inputs, carrying the R-beat payload.
REQ-010 SHALL have ports line_valid_o / line_ready_i, output / input, 1 each, the assembled-line handshake.
REQ-011 SHALL have outputs line_data_o [DATA_WIDTH*LINE_BEATS], line_id_o [ID_WIDTH], line_user_o [USER_WIDTH] and line_err_o [1], carrying the assembled line.
REQ-012 SHALL have port proto_err_o, output, 1, a one-cycle protocol-error pulse.

Function
REQ-013 SHALL accept a beat on slave_valid_i & slave_ready_o.
REQ-014 SHALL drive slave_ready_o = ~line_valid_o | line_ready_i, combinationally.
REQ-015 SHALL keep a beat counter cnt of width clog2(LINE_BEATS), with states COLLECT (line_valid_o=0) and HOLD (line_valid_o=1).
REQ-016 SHALL write accepted beat k into line_data_o[k*DATA_WIDTH +: DATA_WIDTH], with beat 0 in the LSBs.
REQ-017 SHALL latch line_id_o and line_user_o from beat 0 of each line.
REQ-018 SHALL set line_err_o as the OR of slave_resp_i[1] over all beats of the line, so SLVERR/DECERR on any beat flags the whole line.
REQ-019 SHALL, on accepting beat LINE_BEATS-1, wrap cnt to 0 and set line_valid_o the next cycle, which gives 1-cycle latency from the last beat to line_valid_o.
REQ-020 SHALL hold line_valid_o and all line_* outputs stable until line_ready_i=1.
REQ-021 SHALL, on simultaneous line handshake and beat acceptance in HOLD, clear line_valid_o, store the beat as beat 0 of the next line, reset line_err_o to that beat's resp[1], and lose no data.
REQ-022 SHALL, on line_ready_i in HOLD with no new beat, enter COLLECT with cnt=0.
REQ-023 SHALL NOT use slave_last_i to delimit lines; cnt alone delimits lines.

Reset
REQ-024 SHALL, while rst_i=1, force line_valid_o=0, cnt=0, line_err_o=0, proto_err_o=0 and line_data_o/line_id_o/line_user_o=0.
REQ-025 SHALL discard any partial line on reset assertion mid-line, and the first accepted beat after reset SHALL be beat 0.
REQ-026 SHALL drive slave_ready_o=1 during reset (~line_valid_o=1), but no beat SHALL be stored while rst_i=1.

Configuration
REQ-027 SHALL, with macro AXI_R_ASM_LAST_CHECK_EN defined, pulse proto_err_o for one cycle after an accepted beat where slave_last_i != (cnt==LINE_BEATS-1), or where a beat with cnt!=0 has slave_id_i != the latched line_id_o.
REQ-028 SHALL leave line assembly unchanged by a protocol error.
REQ-029 SHALL, without AXI_R_ASM_LAST_CHECK_EN, tie proto_err_o to 0 and include no check logic.

Verification
REQ-030 SHALL cover: 4 beats of 0x11..,0x22..,0x33..,0x44.. (id=3, resp=0, last on beat 3), line_ready_i=1 -> line_valid_o one cycle after beat 3, line_data_o = {0x44..,0x33..,0x22..,0x11..}, line_id_o=3, line_err_o=0.
REQ-031 SHALL cover: beat 2 resp=2'b10 -> line_err_o=1; the next clean line -> line_err_o=0.
REQ-032 SHALL cover: line_ready_i=0 for 5 cycles with slave_valid_i=1 -> slave_ready_o=0 and outputs stable; line_ready_i=1 -> line handshake and beat 0 of the next line accepted in the same cycle.
REQ-033 SHALL cover: 8 back-to-back beats with line_ready_i=1 -> two lines, zero bubbles on slave_ready_o.
REQ-034 SHALL cover: rst_i=1 after 2 beats, then 4 new beats -> the line contains only the 4 new beats.
REQ-035 SHALL cover, with AXI_R_ASM_LAST_CHECK_EN: last on beat 1 -> proto_err_o=1 for exactly 1 cycle and the line still completes after 4 beats; without the macro -> proto_err_o stays 0.

Source files
------------

// File: rtl/axi_r_line_assembler.sv
// Purpose : packs LINE_BEATS consecutive AXI R beats into one wide line (beat 0 in the LSBs).
// Latency : line_valid_o rises one cycle after the final beat is accepted.
// Backpres: slave_ready_o = ~line_valid_o | line_ready_i; a held line stalls R beats until it drains.
// Optional: define AXI_R_ASM_LAST_CHECK_EN to enable the RLAST/RID consistency check on proto_err_o.

module axi_r_line_assembler #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6,
    parameter int LINE_BEATS = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             slave_valid_i,
    output logic                             slave_ready_o,
    input  logic [DATA_WIDTH-1:0]            slave_data_i,
    input  logic [1:0]                       slave_resp_i,
    input  logic [USER_WIDTH-1:0]            slave_user_i,
    input  logic [ID_WIDTH-1:0]              slave_id_i,
    input  logic                             slave_last_i,
    output logic                             line_valid_o,
    input  logic                             line_ready_i,
    output logic [DATA_WIDTH*LINE_BEATS-1:0] line_data_o,
    output logic [ID_WIDTH-1:0]              line_id_o,
    output logic [USER_WIDTH-1:0]            line_user_o,
    output logic                             line_err_o,
    output logic                             proto_err_o
);

    localparam int CNT_W = $clog2(LINE_BEATS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_BEATS - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                                state;
    logic [CNT_W-1:0]                      cnt;
    logic [LINE_BEATS-1:0][DATA_WIDTH-1:0] data_q;
    logic [ID_WIDTH-1:0]                   id_q;
    logic [USER_WIDTH-1:0]                 user_q;
    logic                                  err_q;

    logic beat_acc;
    logic line_acc;
    logic last_beat;

    // A held line only blocks new beats while the consumer is not taking it,
    // so a draining line and beat 0 of the next line can move in the same cycle.
    assign line_valid_o  = (state == HOLD);
    assign slave_ready_o = ~line_valid_o | line_ready_i;
    assign beat_acc      = slave_valid_i & slave_ready_o;
    assign line_acc      = line_valid_o & line_ready_i;
    assign last_beat     = (cnt == LAST_IDX);

    assign line_data_o = data_q;
    assign line_id_o   = id_q;
    assign line_user_o = user_q;
    assign line_err_o  = err_q;

    // Control FSM: beat counter alone delimits lines; RLAST never steers it.
    // In HOLD cnt is already 0, so a beat taken during the drain starts the next line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= COLLECT;
            cnt   <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (beat_acc && last_beat) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (line_acc) begin
                        state <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
            if (beat_acc) begin
                cnt <= last_beat ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // Datapath: beat k lands in slot k; id/user come from beat 0 and the error
    // flag restarts on beat 0 then accumulates RRESP[1] (SLVERR/DECERR) across the line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            id_q   <= '0;
            user_q <= '0;
            err_q  <= 1'b0;
        end else if (beat_acc) begin
            data_q[cnt] <= slave_data_i;
            if (cnt == '0) begin
                id_q   <= slave_id_i;
                user_q <= slave_user_i;
                err_q  <= slave_resp_i[1];
            end else begin
                err_q  <= err_q | slave_resp_i[1];
            end
        end
    end

`ifdef AXI_R_ASM_LAST_CHECK_EN
    logic proto_q;

    // Flag an RLAST that disagrees with the counter's line boundary, or an RID
    // that changes mid-line. Reporting only; assembly carries on regardless.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            proto_q <= 1'b0;
        end else begin
            proto_q <= beat_acc &&
                       ((slave_last_i != last_beat) ||
                        ((cnt != '0) && (slave_id_i != id_q)));
        end
    end

    assign proto_err_o = proto_q;
`else
    logic unused_last;

    assign unused_last = slave_last_i;
    assign proto_err_o = 1'b0;
`endif

endmodule
